// File: rtl/secp256k1_mult.sv
// rtl/secp256k1_mult.sv - iterative 256x256-bit multiplier producing the full 512-bit product
//
// One 64x64 limb product per cycle, schoolbook-accumulated into a 512-bit
// register. A CTL_BITS tag travels with each operation. One operation is in
// flight at a time.
//
// Ports:
//   i_clk            clock
//   i_rst            synchronous reset, active low
//   i_dat_a/i_dat_b  256-bit unsigned operands
//   i_ctl            sideband tag, captured with the operands
//   i_val/o_rdy      input handshake
//   o_dat            512-bit product A*B
//   o_ctl            captured tag
//   o_val/i_rdy      output handshake
//
// Optional build macro SECP256K1_MULT_PIPE_EN: registers the 128-bit partial
// product before accumulation. This adds one drain cycle to MULT, giving
// 18-cycle latency instead of 17. Results are identical in both builds.
module secp256k1_mult #(
   parameter int CTL_BITS = 8
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic [255:0]        i_dat_a,
   input  logic [255:0]        i_dat_b,
   input  logic [CTL_BITS-1:0] i_ctl,
   input  logic                i_val,
   output logic                o_rdy,
   output logic [511:0]        o_dat,
   output logic [CTL_BITS-1:0] o_ctl,
   output logic                o_val,
   input  logic                i_rdy
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_MULT = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [255:0]        a_q, a_d;
   logic [255:0]        b_q, b_d;
   logic [CTL_BITS-1:0] ctl_q, ctl_d;
   logic [511:0]        acc_q, acc_d;
   logic [4:0]          cnt_q, cnt_d;

   logic [1:0]          limb_i;
   logic [1:0]          limb_j;
   logic [63:0]         limb_a;
   logic [63:0]         limb_b;
   logic [127:0]        pp;
   logic [8:0]          pp_shamt;

`ifdef SECP256K1_MULT_PIPE_EN
   // Partial product and its shift are staged one cycle ahead of the add.
   logic [127:0]        pp_q, pp_d;
   logic [8:0]          sh_q, sh_d;
   localparam logic [4:0] LAST_CNT = 5'd16;
`else
   localparam logic [4:0] LAST_CNT = 5'd15;
`endif

   // cnt walks i (A limb) in the upper two bits and j (B limb) in the lower two.
   assign limb_i   = cnt_q[3:2];
   assign limb_j   = cnt_q[1:0];
   assign limb_a   = a_q[{limb_i, 6'b0} +: 64];
   assign limb_b   = b_q[{limb_j, 6'b0} +: 64];
   assign pp       = {64'b0, limb_a} * {64'b0, limb_b};
   // Weight of a[i]*b[j] is 2^(64*(i+j)).
   assign pp_shamt = {({1'b0, limb_i} + {1'b0, limb_j}), 6'b0};

   // Outputs read zero while reset is held, before the registers have cleared.
   assign o_dat = i_rst ? acc_q : '0;
   assign o_ctl = i_rst ? ctl_q : '0;

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      ctl_d   = ctl_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      o_rdy   = 1'b0;
      o_val   = 1'b0;
`ifdef SECP256K1_MULT_PIPE_EN
      pp_d    = pp_q;
      sh_d    = sh_q;
`endif
      case (state_q)
         ST_IDLE: begin
            o_rdy = i_rst;
            if (i_val && i_rst) begin
               a_d     = i_dat_a;
               b_d     = i_dat_b;
               ctl_d   = i_ctl;
               acc_d   = '0;
               cnt_d   = '0;
               state_d = ST_MULT;
            end
         end
         ST_MULT: begin
            cnt_d = cnt_q + 5'd1;
`ifdef SECP256K1_MULT_PIPE_EN
            pp_d = pp;
            sh_d = pp_shamt;
            // The first cycle only fills the stage; the last only drains it.
            if (cnt_q != 5'd0) begin
               acc_d = acc_q + ({384'b0, pp_q} << sh_q);
            end
`else
            acc_d = acc_q + ({384'b0, pp} << pp_shamt);
`endif
            if (cnt_q == LAST_CNT) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            o_val = i_rst;
            if (i_rdy) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         state_q <= ST_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         ctl_q   <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
`ifdef SECP256K1_MULT_PIPE_EN
         pp_q    <= '0;
         sh_q    <= '0;
`endif
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         ctl_q   <= ctl_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
`ifdef SECP256K1_MULT_PIPE_EN
         pp_q    <= pp_d;
         sh_q    <= sh_d;
`endif
      end
   end

endmodule

// File: tb/tb_secp256k1_mult.sv
// tb/tb_secp256k1_mult.sv - directed self-checking bench for secp256k1_mult
module tb_secp256k1_mult;

`ifdef SECP256K1_MULT_PIPE_EN
   localparam int LAT = 18;
`else
   localparam int LAT = 17;
`endif

   logic         clk;
   logic         i_rst;
   logic [255:0] i_dat_a;
   logic [255:0] i_dat_b;
   logic [7:0]   i_ctl;
   logic         i_val;
   logic         o_rdy;
   logic [511:0] o_dat;
   logic [7:0]   o_ctl;
   logic         o_val;
   logic         i_rdy;

   int n_cmp = 0;
   int n_err = 0;

   secp256k1_mult #(.CTL_BITS(8)) dut (
      .i_clk   (clk),
      .i_rst   (i_rst),
      .i_dat_a (i_dat_a),
      .i_dat_b (i_dat_b),
      .i_ctl   (i_ctl),
      .i_val   (i_val),
      .o_rdy   (o_rdy),
      .o_dat   (o_dat),
      .o_ctl   (o_ctl),
      .o_val   (o_val),
      .i_rdy   (i_rdy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Waits for o_rdy, presents one operation, returns just after the accept edge.
   task automatic start_op(input logic [255:0] a, input logic [255:0] b, input logic [7:0] c);
      int n;
      n = 0;
      @(negedge clk);
      while (!o_rdy && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("accept_rdy", o_rdy, 1);
      i_dat_a = a;
      i_dat_b = b;
      i_ctl   = c;
      i_val   = 1'b1;
      @(posedge clk);
      #1;
      i_val   = 1'b0;
   endtask

   // lat = index of the first edge after accept that samples o_val high (0 on timeout).
   task automatic wait_out(output int lat);
      lat = 0;
      for (int n = 1; n <= 40; n++) begin
         @(negedge clk);
         if (o_val) begin
            lat = n;
            break;
         end
      end
   endtask

   task automatic run_op(input string tag, input logic [255:0] a, input logic [255:0] b,
                         input logic [7:0] c, input logic [511:0] exp);
      int lat;
      start_op(a, b, c);
      wait_out(lat);
      chk({tag, "_lat"}, lat, LAT);
      chk({tag, "_dat"}, o_dat, exp);
      chk({tag, "_ctl"}, o_ctl, c);
      @(negedge clk);
      chk({tag, "_val_drop"}, o_val, 0);
      chk({tag, "_rdy_back"}, o_rdy, 1);
   endtask

   initial begin
      logic [511:0] e;
      int           lat;
      int           seen;

      i_rst   = 1'b0;
      i_dat_a = '0;
      i_dat_b = '0;
      i_ctl   = '0;
      i_val   = 1'b0;
      i_rdy   = 1'b1;

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_val", o_val, 0);
      chk("rst_rdy", o_rdy, 0);
      chk("rst_dat", o_dat, 0);
      chk("rst_ctl", o_ctl, 0);
      i_rst = 1'b1;
      @(negedge clk);
      chk("idle_rdy", o_rdy, 1);
      chk("idle_val", o_val, 0);

      // Basic product
      run_op("one", 256'd1, 256'd1, 8'h5A, 512'd1);

      // Carry across the 256-bit boundary
      e = 512'd1 << 256;
      run_op("limb_carry", 256'd1 << 255, 256'd2, 8'h11, e);

      // Maximum operands: 2^512 - 2^257 + 1
      e = {{255{1'b1}}, 1'b0, {255{1'b0}}, 1'b1};
      run_op("max", {256{1'b1}}, {256{1'b1}}, 8'hFF, e);

      // Single-limb square with carry into the next limb
      e = 512'h0000_0000_0000_0000_0000_0000_0000_0000_FFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001;
      run_op("limb_sq", 256'hFFFF_FFFF_FFFF_FFFF, 256'hFFFF_FFFF_FFFF_FFFF, 8'h22, e);

      // (2^64+1)(2^64-1) = 2^128-1: cross terms must cancel through the carries
      e = {384'b0, {128{1'b1}}};
      run_op("cross", (256'd1 << 64) + 256'd1, 256'hFFFF_FFFF_FFFF_FFFF, 8'h33, e);

      // 2^216 * 2^217 = 2^433
      e = 512'd1 << 433;
      run_op("pow2", 256'd1 << 216, 256'd1 << 217, 8'h44, e);

      // Back-pressure: hold i_rdy low for 5 cycles, offer a second op meanwhile
      i_rdy = 1'b0;
      start_op(256'd3, 256'd5, 8'hA5);
      wait_out(lat);
      chk("bp_lat", lat, LAT);
      i_dat_a = 256'd2;
      i_dat_b = 256'd4;
      i_ctl   = 8'h6C;
      i_val   = 1'b1;
      for (int k = 0; k < 5; k++) begin
         chk("bp_dat", o_dat, 512'd15);
         chk("bp_ctl", o_ctl, 8'hA5);
         chk("bp_val", o_val, 1);
         chk("bp_rdy", o_rdy, 0);
         @(negedge clk);
      end
      i_rdy = 1'b1;
      chk("bp_last_dat", o_dat, 512'd15);
      @(negedge clk);
      chk("bp_val_drop", o_val, 0);
      chk("bp_rdy_back", o_rdy, 1);
      @(posedge clk);
      #1;
      i_val = 1'b0;
      wait_out(lat);
      chk("bp2_lat", lat, LAT);
      chk("bp2_dat", o_dat, 512'd8);
      chk("bp2_ctl", o_ctl, 8'h6C);
      @(negedge clk);

      // Reset while in MULT with cnt = 7
      start_op(256'd11, 256'd13, 8'h77);
      repeat (8) @(negedge clk);
      i_rst = 1'b0;
      @(posedge clk);
      #1;
      chk("mid_rst_rdy", o_rdy, 0);
      chk("mid_rst_val", o_val, 0);
      chk("mid_rst_dat", o_dat, 0);
      @(posedge clk);
      @(negedge clk);
      i_rst = 1'b1;
      seen = 0;
      for (int k = 0; k < 25; k++) begin
         @(negedge clk);
         if (o_val) seen++;
      end
      chk("aborted_no_val", seen, 0);
      run_op("after_rst", 256'd7, 256'd9, 8'h3C, 512'd63);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
